pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the address/count width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the return-stack entry count (power of two, minimum 2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port op  input  3  operation select: 000 HOLD, 001 INC, 010 LOAD, 011 REL, 100 CALL, 101 RET, 110/111 reserved.
REQ-006 The block SHALL have port cond  input  1  branch-taken qualifier for LOAD/REL/CALL/RET.
REQ-007 The block SHALL have port target  input  WIDTH  absolute destination for LOAD and CALL.
REQ-008 The block SHALL have port offset  input  WIDTH  two's-complement displacement for REL.
REQ-009 The block SHALL have port count  output  WIDTH  current program counter, registered.
REQ-010 The block SHALL have port sp  output  clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
REQ-011 The block SHALL have ports stack_full and stack_empty  output  1 each  combinational decodes of sp==DEPTH and sp==0.
REQ-012 The block SHALL have ports ovf_err and unf_err  output  1 each  sticky error flags.

Function
REQ-013 HOLD and reserved encodings SHALL leave count, stack and flags unchanged.
REQ-014 INC SHALL set count to count+1, modulo 2^WIDTH (0xFFFF wraps to 0x0000 at WIDTH=16).
REQ-015 LOAD with cond=1 SHALL set count to target.
REQ-016 REL with cond=1 SHALL set count to count+offset, modulo 2^WIDTH; a negative offset moves backward.
REQ-017 CALL with cond=1 and stack not full SHALL, in one cycle, push count+1 (modulo 2^WIDTH), increment sp and set count to target.
REQ-018 RET with cond=1 and stack not empty SHALL, in one cycle, set count to the top entry and decrement sp.
REQ-019 LOAD/REL/CALL/RET with cond=0 SHALL behave exactly as INC, with stack and flags unchanged.
REQ-020 CALL with cond=1 while stack_full SHALL leave count and the stack unchanged and set ovf_err.
REQ-021 RET with cond=1 while stack_empty SHALL leave count and sp unchanged and set unf_err.
REQ-022 ovf_err and unf_err SHALL stay set until reset; further legal operations SHALL still execute normally.
REQ-023 All outputs SHALL reflect a new operation one clock after it is presented; there SHALL be no combinational path from op/target/offset to count.
REQ-024 Back-to-back CALL/RET on consecutive cycles SHALL be supported with no bubble; a RET in the cycle after a CALL SHALL return the just-pushed value.
REQ-025 Stack entries above sp SHALL be treated as don't-care and SHALL never be observable on count.

Reset
REQ-026 reset=1 at a rising edge SHALL set count=0, sp=0, ovf_err=0 and unf_err=0, overriding any op presented in that cycle.
REQ-027 Reset asserted mid-sequence (for example between a CALL and its RET) SHALL discard all stack contents; a following RET SHALL be an underflow.
REQ-028 Stack storage SHALL NOT require reset.

Structure
REQ-029 Operation encodings (HOLD, INC, LOAD, REL, CALL, RET) SHALL be named constants in the shared package pc_stack_pkg, used by both the block and the controller.
REQ-030 The LIFO SHALL be a sub-module named return_stack (parameters WIDTH and DEPTH, push/pop/data, sp, full/empty); pc_stack_unit SHALL own the count register and the error flags.

Verification
REQ-031 Reset, then INC x3 -> count=0x0003, sp=0, stack_empty=1, both error flags 0.
REQ-032 count=0x0010, CALL target=0x0200 cond=1, then RET cond=1 -> count goes 0x0200 then 0x0011; sp goes 1 then 0.
REQ-033 count=0x0100, REL offset=0xFFFC cond=1 -> count=0x00FC; then LOAD target=0x0ABC cond=0 -> count=0x00FD.
REQ-034 Nine CALLs with DEPTH=8 -> sp=8, stack_full=1; ninth CALL leaves count at the eighth target and sets ovf_err; eight RETs then unwind in LIFO order.
REQ-035 RET cond=1 from reset -> count=0, unf_err=1; a following INC -> count=1 with unf_err still 1.
REQ-036 count=0xFFFF, INC -> 0x0000; count=0xFFFF, CALL target=0x0040 -> pushed value 0x0000; reset asserted together with CALL -> count=0, sp=0.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-stack unit:
// operation encodings used by the block and by the controller that drives it.
package pc_stack_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_REL  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. The top entry is read combinationally so a pop
// can update the program counter in the same cycle it is requested.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       full,
  output logic                       empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;

  // When sp==DEPTH the low bits wrap to 0, so sp-1 still selects entry DEPTH-1.
  assign top_idx  = sp[AW-1:0] - AW'(1);
  assign top_data = mem[top_idx];
  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Storage carries no reset; entries at or above sp are never read out.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with conditional branch, relative jump and call/return
// through a hardware return stack; overflow/underflow are sticky error flags.
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             op,
  input  logic                   cond,
  input  logic [WIDTH-1:0]       target,
  input  logic [WIDTH-1:0]       offset,
  output logic [WIDTH-1:0]       count,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   ovf_err,
  output logic                   unf_err
);

  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] top_data;
  logic             push;
  logic             pop;
  logic             set_ovf;
  logic             set_unf;

  assign count_inc = count + WIDTH'(1);

  always_comb begin
    count_nxt = count;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (op)
      OP_INC:  count_nxt = count_inc;
      OP_LOAD: count_nxt = cond ? target : count_inc;
      OP_REL:  count_nxt = cond ? (count + offset) : count_inc;
      OP_CALL: begin
        if (!cond) begin
          count_nxt = count_inc;
        end else if (stack_full) begin
          set_ovf = 1'b1;
        end else begin
          push      = 1'b1;
          count_nxt = target;
        end
      end
      OP_RET: begin
        if (!cond) begin
          count_nxt = count_inc;
        end else if (stack_empty) begin
          set_unf = 1'b1;
        end else begin
          pop       = 1'b1;
          count_nxt = top_data;
        end
      end
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count   <= count_nxt;
      ovf_err <= ovf_err | set_ovf;
      unf_err <= unf_err | set_unf;
    end
  end

  return_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (count_inc),
    .top_data  (top_data),
    .sp        (sp),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: each scenario task drives operations and
// compares registered outputs one cycle later against hand-computed values.
module tb_pc_stack_unit;
  import pc_stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] count;
  logic [3:0]       sp;
  logic             stack_full;
  logic             stack_empty;
  logic             ovf_err;
  logic             unf_err;

  int tests_run = 0;
  int tests_failed = 0;

  pc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .cond        (cond),
    .target      (target),
    .offset      (offset),
    .count       (count),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one operation, sample #1 after the edge that takes it
  task automatic drive(input logic [2:0] o, input logic c,
                       input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
    op = o; cond = c; target = t; offset = f;
    @(posedge clk);
    #1;
    op = OP_HOLD; cond = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(OP_HOLD, 1'b0, '0, '0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(OP_INC, 1'b1, 16'h1234, '0);
    reset = 1'b0;
    tests_run++;
    if (count !== 16'h0000 || sp !== 4'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0
        || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: count=%h sp=%0d empty=%b full=%b ovf=%b unf=%b, want 0000 0 1 0 0 0",
               count, sp, stack_empty, stack_full, ovf_err, unf_err);
    end
  endtask

  task automatic test_inc();
    do_reset();
    for (int i = 0; i < 3; i++) drive(OP_INC, 1'b0, '0, '0);
    tests_run++;
    if (count !== 16'h0003 || sp !== 4'd0 || stack_empty !== 1'b1 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL inc_x3: count=%h sp=%0d empty=%b ovf=%b unf=%b, want 0003 0 1 0 0",
               count, sp, stack_empty, ovf_err, unf_err);
    end
  endtask

  task automatic test_hold();
    drive(OP_HOLD, 1'b1, 16'h5555, 16'h5555);
    drive(3'b110, 1'b1, 16'h5555, 16'h5555);
    drive(3'b111, 1'b1, 16'h5555, 16'h5555);
    tests_run++;
    if (count !== 16'h0003 || sp !== 4'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_reserved: count=%h sp=%0d ovf=%b unf=%b, want 0003 0 0 0",
               count, sp, ovf_err, unf_err);
    end
    drive(OP_CALL, 1'b0, 16'h0777, '0);
    drive(OP_RET, 1'b0, '0, '0);
    drive(OP_REL, 1'b0, '0, 16'h0100);
    tests_run++;
    if (count !== 16'h0006 || sp !== 4'd0 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL cond0_as_inc: count=%h sp=%0d unf=%b, want 0006 0 0", count, sp, unf_err);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    drive(OP_LOAD, 1'b1, 16'h0010, '0);
    drive(OP_CALL, 1'b1, 16'h0200, '0);
    tests_run++;
    if (count !== 16'h0200 || sp !== 4'd1 || stack_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL call: count=%h sp=%0d empty=%b, want 0200 1 0", count, sp, stack_empty);
    end
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0011 || sp !== 4'd0 || stack_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL ret: count=%h sp=%0d empty=%b, want 0011 0 1", count, sp, stack_empty);
    end
  endtask

  task automatic test_rel();
    do_reset();
    drive(OP_LOAD, 1'b1, 16'h0100, '0);
    drive(OP_REL, 1'b1, '0, 16'hFFFC);
    tests_run++;
    if (count !== 16'h00FC) begin
      tests_failed++;
      $display("FAIL rel_back: count=%h, want 00fc", count);
    end
    drive(OP_LOAD, 1'b0, 16'h0ABC, '0);
    tests_run++;
    if (count !== 16'h00FD) begin
      tests_failed++;
      $display("FAIL load_cond0: count=%h, want 00fd", count);
    end
    drive(OP_REL, 1'b1, '0, 16'h0013);
    tests_run++;
    if (count !== 16'h0110) begin
      tests_failed++;
      $display("FAIL rel_fwd: count=%h, want 0110", count);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_v;
    logic [WIDTH-1:0] pc;
    do_reset();
    pc = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(pc + 16'h0001);
      pc = 16'h1000 + 16'(i * 16);
      drive(OP_CALL, 1'b1, pc, '0);
    end
    tests_run++;
    if (count !== 16'h1070 || sp !== 4'd8 || stack_full !== 1'b1 || ovf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_8: count=%h sp=%0d full=%b ovf=%b, want 1070 8 1 0",
               count, sp, stack_full, ovf_err);
    end
    drive(OP_CALL, 1'b1, 16'h1080, '0);
    tests_run++;
    if (count !== 16'h1070 || sp !== 4'd8 || ovf_err !== 1'b1 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL call_ovf: count=%h sp=%0d ovf=%b unf=%b, want 1070 8 1 0",
               count, sp, ovf_err, unf_err);
    end
    for (int j = 0; j < DEPTH; j++) begin
      exp_v = exp_q.pop_back();
      drive(OP_RET, 1'b1, '0, '0);
      tests_run++;
      if (count !== exp_v || sp !== 4'(DEPTH - 1 - j)) begin
        tests_failed++;
        $display("FAIL unwind_%0d: count=%h sp=%0d, want %h %0d", j, count, sp, exp_v, DEPTH - 1 - j);
      end
    end
    tests_run++;
    if (ovf_err !== 1'b1 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_sticky: ovf=%b empty=%b full=%b, want 1 1 0", ovf_err, stack_empty, stack_full);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0000 || sp !== 4'd0 || unf_err !== 1'b1 || ovf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ret_unf: count=%h sp=%0d unf=%b ovf=%b, want 0000 0 1 0", count, sp, unf_err, ovf_err);
    end
    drive(OP_INC, 1'b0, '0, '0);
    tests_run++;
    if (count !== 16'h0001 || unf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL unf_sticky: count=%h unf=%b, want 0001 1", count, unf_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(OP_LOAD, 1'b1, 16'hFFFF, '0);
    drive(OP_INC, 1'b0, '0, '0);
    tests_run++;
    if (count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL inc_wrap: count=%h, want 0000", count);
    end
    drive(OP_LOAD, 1'b1, 16'hFFFF, '0);
    drive(OP_CALL, 1'b1, 16'h0040, '0);
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0000 || sp !== 4'd0) begin
      tests_failed++;
      $display("FAIL call_wrap_push: count=%h sp=%0d, want 0000 0", count, sp);
    end
    drive(OP_LOAD, 1'b1, 16'h0050, '0);
    reset = 1'b1;
    drive(OP_CALL, 1'b1, 16'h0060, '0);
    reset = 1'b0;
    tests_run++;
    if (count !== 16'h0000 || sp !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_with_call: count=%h sp=%0d, want 0000 0", count, sp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(OP_CALL, 1'b1, 16'h0123, '0);
    do_reset();
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0000 || sp !== 4'd0 || unf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_ret: count=%h sp=%0d unf=%b, want 0000 0 1", count, sp, unf_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(OP_CALL, 1'b1, 16'h0300, '0);
    drive(OP_CALL, 1'b1, 16'h0400, '0);
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0301 || sp !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_ret1: count=%h sp=%0d, want 0301 1", count, sp);
    end
    drive(OP_CALL, 1'b1, 16'h0500, '0);
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0302 || sp !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_ret2: count=%h sp=%0d, want 0302 1", count, sp);
    end
    drive(OP_RET, 1'b1, '0, '0);
    tests_run++;
    if (count !== 16'h0001 || sp !== 4'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ret3: count=%h sp=%0d ovf=%b unf=%b, want 0001 0 0 0",
               count, sp, ovf_err, unf_err);
    end
  endtask

  initial begin
    reset = 1'b1; op = OP_HOLD; cond = 1'b0; target = '0; offset = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_inc();
    test_hold();
    test_call_ret();
    test_rel();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
